// File: rtl/add_accum_if.sv
// Handshake bundle for add_accum: adder-result input side and batch-result output side.
// master drives samples and consumes results; slave is the accumulator.
interface add_accum_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int COUNT     = 4
);
    localparam int CNT_W = $clog2(COUNT + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     sum;
    logic                 cout;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] acc_out;
    logic [CNT_W-1:0]     out_count;
    logic                 ovf;

    modport master (
        output in_valid, sum, cout, out_ready,
        input  in_ready, out_valid, acc_out, out_count, ovf
    );

    modport slave (
        input  in_valid, sum, cout, out_ready,
        output in_ready, out_valid, acc_out, out_count, ovf
    );
endinterface

// File: rtl/add_accum.sv
// Batch accumulator for {cout,sum} adder results; presents total, count and sticky overflow.
// Optional macro ADD_ACCUM_SATURATE_EN clamps the total at all-ones on overflow instead of wrapping.
module add_accum #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int COUNT     = 4
) (
    input  logic       clk,
    input  logic       rst,
    add_accum_if.slave bus
);
    localparam int CNT_W = $clog2(COUNT + 1);
    localparam int SUM_W = ACC_WIDTH + 1;

    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] DONE = 1'b1;

    logic [0:0]           state, state_nxt;
    logic [ACC_WIDTH-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 ovf, ovf_nxt;
    logic [SUM_W-1:0]     total;
    logic                 accept;
    logic                 release_batch;
    logic                 last;

    assign accept        = bus.in_valid && (state == ACC);
    assign release_batch = bus.out_ready && (state == DONE);
    assign last          = (cnt == CNT_W'(COUNT - 1));

    // One extra bit so the carry out of the top accumulator bit flags overflow.
    assign total = {1'b0, acc} + SUM_W'({bus.cout, bus.sum});

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        if (accept) begin
`ifdef ADD_ACCUM_SATURATE_EN
            acc_nxt = (total[ACC_WIDTH] || ovf) ? '1 : total[ACC_WIDTH-1:0];
`else
            acc_nxt = total[ACC_WIDTH-1:0];
`endif
            cnt_nxt = cnt + CNT_W'(1);
            ovf_nxt = ovf | total[ACC_WIDTH];
            if (last) begin
                state_nxt = DONE;
            end
        end else if (release_batch) begin
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
            state_nxt = ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    assign bus.in_ready  = (state == ACC);
    assign bus.out_valid = (state == DONE);
    assign bus.acc_out   = acc;
    assign bus.out_count = cnt;
    assign bus.ovf       = ovf;
endmodule

// File: tb/tb_add_accum.sv
// Scoreboard bench for add_accum: default-width instance plus a 10-bit accumulator for overflow cases.
module tb_add_accum;
    typedef struct packed {
        logic [15:0] acc;
        logic [2:0]  cnt;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t q_def[$];
    exp_t q_w[$];

    logic [8:0] basic_v [4] = '{9'h000, 9'h040, 9'h100, 9'h0FF};

    always #5 clk = ~clk;

    add_accum_if #(.WIDTH(8), .ACC_WIDTH(16), .COUNT(4)) bd ();
    add_accum_if #(.WIDTH(8), .ACC_WIDTH(10), .COUNT(4)) bw ();

    add_accum #(.WIDTH(8), .ACC_WIDTH(16), .COUNT(4)) u_def (.clk(clk), .rst(rst), .bus(bd.slave));
    add_accum #(.WIDTH(8), .ACC_WIDTH(10), .COUNT(4)) u_w   (.clk(clk), .rst(rst), .bus(bw.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_def(input logic [8:0] s);
        bd.in_valid = 1'b1;
        {bd.cout, bd.sum} = s;
    endtask

    task automatic drive_w(input logic [8:0] s);
        bw.in_valid = 1'b1;
        {bw.cout, bw.sum} = s;
    endtask

    // Monitors: compare each completed output handshake against the scoreboard.
    always @(negedge clk) begin
        if (!rst && bd.out_valid && bd.out_ready) begin
            if (q_def.size() == 0) begin
                chk("def_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_def.pop_front();
                chk("def_acc_out", 32'(bd.acc_out), 32'(e.acc));
                chk("def_out_count", 32'(bd.out_count), 32'(e.cnt));
                chk("def_ovf", 32'(bd.ovf), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bw.out_valid && bw.out_ready) begin
            if (q_w.size() == 0) begin
                chk("w_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_w.pop_front();
                chk("w_acc_out", 32'(bw.acc_out), 32'(e.acc));
                chk("w_out_count", 32'(bw.out_count), 32'(e.cnt));
                chk("w_ovf", 32'(bw.ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive_def(9'h1FF);
        drive_w(9'h1FF);
        bd.out_ready = 1'b1;
        bw.out_ready = 1'b1;

        // Reset held two cycles with in_valid asserted
        repeat (2) tick();
        chk("rst_in_ready", 32'(bd.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bd.out_valid), 32'd0);
        chk("rst_acc_out", 32'(bd.acc_out), 32'd0);
        chk("rst_out_count", 32'(bd.out_count), 32'd0);
        chk("rst_ovf", 32'(bd.ovf), 32'd0);
        chk("rst_w_acc_out", 32'(bw.acc_out), 32'd0);
        rst = 1'b0;
        bd.in_valid = 1'b0;
        bw.in_valid = 1'b0;
        tick();

        // Basic batch, out_ready high
        q_def.push_back('{acc: 16'h023F, cnt: 3'd4, ovf: 1'b0});
        for (int i = 0; i < 4; i++) begin
            drive_def(basic_v[i]);
            tick();
            chk("basic_out_valid", 32'(bd.out_valid), (i == 3) ? 32'd1 : 32'd0);
            chk("basic_out_count", 32'(bd.out_count), 32'(i + 1));
        end
        bd.in_valid = 1'b0;
        tick();
        chk("basic_after_acc_out", 32'(bd.acc_out), 32'd0);
        chk("basic_after_in_ready", 32'(bd.in_ready), 32'd1);
        chk("basic_after_out_valid", 32'(bd.out_valid), 32'd0);

        // Backpressure: hold five cycles with stray in_valid pulses
        bd.out_ready = 1'b0;
        q_def.push_back('{acc: 16'h023F, cnt: 3'd4, ovf: 1'b0});
        for (int i = 0; i < 4; i++) begin
            drive_def(basic_v[i]);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive_def(9'h1FF);
            bd.in_valid = (i % 2 == 0);
            tick();
            chk("bp_out_valid", 32'(bd.out_valid), 32'd1);
            chk("bp_acc_out", 32'(bd.acc_out), 32'h023F);
            chk("bp_in_ready", 32'(bd.in_ready), 32'd0);
            chk("bp_out_count", 32'(bd.out_count), 32'd4);
        end
        bd.in_valid = 1'b0;
        bd.out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", 32'(bd.out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(bd.in_ready), 32'd1);

        // Overflow on the 10-bit accumulator
`ifdef ADD_ACCUM_SATURATE_EN
        q_w.push_back('{acc: 16'h03FF, cnt: 3'd4, ovf: 1'b1});
`else
        q_w.push_back('{acc: 16'h03FC, cnt: 3'd4, ovf: 1'b1});
`endif
        for (int i = 0; i < 4; i++) begin
            drive_w(9'h1FF);
            tick();
            if (i == 1) begin
                chk("w_2nd_acc_out", 32'(bw.acc_out), 32'h03FE);
                chk("w_2nd_ovf", 32'(bw.ovf), 32'd0);
            end
            if (i == 2) begin
`ifdef ADD_ACCUM_SATURATE_EN
                chk("w_3rd_acc_out", 32'(bw.acc_out), 32'h03FF);
`else
                chk("w_3rd_acc_out", 32'(bw.acc_out), 32'h01FD);
`endif
                chk("w_3rd_ovf", 32'(bw.ovf), 32'd1);
            end
        end
        bw.in_valid = 1'b0;
        tick();
        chk("w_after_ovf", 32'(bw.ovf), 32'd0);

        // Mid-batch reset discards the partial batch
        drive_def(9'h040);
        tick();
        tick();
        chk("mid_partial_count", 32'(bd.out_count), 32'd2);
        bd.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_count", 32'(bd.out_count), 32'd0);
        chk("mid_rst_acc_out", 32'(bd.acc_out), 32'd0);
        rst = 1'b0;
        q_def.push_back('{acc: 16'h0004, cnt: 3'd4, ovf: 1'b0});
        for (int i = 0; i < 4; i++) begin
            drive_def(9'h001);
            tick();
        end
        bd.in_valid = 1'b0;
        repeat (2) tick();

        chk("def_queue_drained", 32'(q_def.size()), 32'd0);
        chk("w_queue_drained", 32'(q_w.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/add_accum.md
# add_accum

Result accumulator directly downstream of the 8-bit `parallelAdder`. It captures each adder result (`cout` concatenated with `sum`) through a valid/ready handshake and accumulates a fixed-size batch into a wider register. It then presents the batch total, sample count and an overflow flag on an output handshake. It turns the combinational adder into a batch-summing datapath stage.

## Interface
- `WIDTH`, 8, adder operand width; each input sample is `WIDTH+1` bits, `{cout,sum}`.
- `ACC_WIDTH`, 16, accumulator width; must be ≥ `WIDTH+1`.
- `COUNT`, 4, samples per batch; must be ≥ 1.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  adder result valid.
- `in_ready`  output  1  block accepts a sample this cycle.
- `sum`  input  WIDTH  adder sum.
- `cout`  input  1  adder carry-out.
- `out_valid`  output  1  batch result valid.
- `out_ready`  input  1  consumer accepts the batch result.
- `acc_out`  output  ACC_WIDTH  batch total.
- `out_count`  output  $clog2(COUNT+1)  samples accumulated so far.
- `ovf`  output  1  sticky: the accumulator exceeded `2^ACC_WIDTH-1` during this batch.

## Operation
- Two states: ACC and DONE. Reset state is ACC.
- **ACC state:**
  - `in_ready`=1 and `out_valid`=0.
  - On accept (`in_valid & in_ready`): `acc_out <= acc_out + zero_ext({cout,sum})` and `out_count <= out_count+1`.
  - Arithmetic is evaluated at `ACC_WIDTH+1` bits. If the carry out of bit `ACC_WIDTH-1` is set, `ovf <= 1`. In default mode the stored value wraps modulo `2^ACC_WIDTH`.
  - When the accept brings `out_count` to `COUNT`, the next state is DONE.
- **DONE state:**
  - `in_ready`=0 and `out_valid`=1.
  - `acc_out`, `out_count` and `ovf` are held stable.
  - On `out_valid & out_ready`: clear `acc_out`, `out_count` and `ovf` to 0; next state is ACC.
- `in_valid` while `in_ready`=0 is ignored; no sample is stored or lost silently, because the upstream must hold it.
- Inputs `sum` and `cout` are sampled only on an accept cycle.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `acc_out`=0, `out_count`=0, `ovf`=0, state ACC.
- `rst` takes effect at the next rising edge from any state, including mid-batch and while `out_valid`=1. A partial batch is discarded.
- Latency: `out_valid` rises on the edge that accepts the COUNT-th sample, so `acc_out` includes that sample in the same cycle `out_valid`=1.
- Throughput: one sample per cycle in ACC.
- After the output handshake, the block is in ACC with `in_ready`=1 on the following cycle. There is no same-cycle bypass between output accept and input accept.
- Total batch period with `out_ready` held high is `COUNT+1` cycles.
- `out_ready` is ignored in ACC.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `ADD_ACCUM_SATURATE_EN`.
- **Defined:** on overflow `acc_out` clamps to `2^ACC_WIDTH-1` and remains there for the rest of the batch. `ovf` is set as in default mode.
- **Undefined (default):** the accumulator wraps modulo `2^ACC_WIDTH`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `in_valid`=1 → all outputs at reset values and `in_ready`=1.
- **Basic batch** (defaults, `out_ready`=1): feed `{cout,sum}` = 0x000, 0x040, 0x100, 0x0FF on 4 consecutive cycles → `out_valid`=1 on the 4th accept edge with `acc_out`=0x023F, `out_count`=4, `ovf`=0. The next cycle shows `acc_out`=0 and `in_ready`=1.
- **Backpressure:** same batch with `out_ready`=0 for 5 cycles → `out_valid`, `acc_out`=0x023F and `in_ready`=0 are held stable. `in_valid` pulses during the hold have no effect. Raising `out_ready` completes the handshake in 1 cycle.
- **Wrap** (`ACC_WIDTH`=10, macro undefined): four samples of 0x1FF → `ovf`=1 after the 3rd sample (`acc_out`=0x1FD). Final `acc_out`=0x3FC and `ovf`=1.
- **Saturate** (`ACC_WIDTH`=10, `ADD_ACCUM_SATURATE_EN` defined): four samples of 0x1FF → final `acc_out`=0x3FF and `ovf`=1.
- **Mid-batch reset:** accept 2 samples of 0x040, assert `rst` for 1 cycle, then feed 4 samples of 0x001 → `acc_out`=0x0004 and `out_count`=4.
